// File: rtl/branch_target_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor_pkg
// Description : Shared types, counter encodings and saturating counter
//               helpers for the fetch-stage branch target predictor.
// Contents    : lc3b_word    - 16-bit machine word / PC
//               lc3b_btb_ctr - 2-bit direction counter
//               BTB_SNT/WNT/WT/ST - counter encodings
//               sat_inc/sat_dec   - saturating counter steps
// Revision    : 1.0 - initial release
// ============================================================================
package branch_target_predictor_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_btb_ctr;

    // Counter MSB is the predicted direction: 1x predicts taken.
    localparam lc3b_btb_ctr BTB_SNT = 2'b00;
    localparam lc3b_btb_ctr BTB_WNT = 2'b01;
    localparam lc3b_btb_ctr BTB_WT  = 2'b10;
    localparam lc3b_btb_ctr BTB_ST  = 2'b11;

    function automatic lc3b_btb_ctr sat_inc(input lc3b_btb_ctr ctr);
        return (ctr == BTB_ST) ? BTB_ST : ctr + 2'b01;
    endfunction

    function automatic lc3b_btb_ctr sat_dec(input lc3b_btb_ctr ctr);
        return (ctr == BTB_SNT) ? BTB_SNT : ctr - 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_predictor_btb_array.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor_btb_array
// Description : Storage for the direct-mapped BTB: per-entry valid bit, tag,
//               target and 2-bit direction counter. Pure storage, no policy.
//               A combinational read path serves the fetch lookup, a second
//               combinational read path exposes the entry being trained, and
//               a single synchronous write port replaces a whole entry.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_fetch_idx  -> o_fetch_{valid,tag,target,ctr}
//               i_upd_idx    -> o_upd_{valid,tag,target,ctr}
//               i_wr_en, i_wr_idx, i_wr_{tag,target,ctr} - write port
//                                  (a write always marks the entry valid)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor_btb_array
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES  = 8,
    parameter int TAG_BITS = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(ENTRIES)-1:0]  i_fetch_idx,
    output logic                        o_fetch_valid,
    output logic [TAG_BITS-1:0]         o_fetch_tag,
    output lc3b_word                    o_fetch_target,
    output lc3b_btb_ctr                 o_fetch_ctr,
    input  logic [$clog2(ENTRIES)-1:0]  i_upd_idx,
    output logic                        o_upd_valid,
    output logic [TAG_BITS-1:0]         o_upd_tag,
    output lc3b_word                    o_upd_target,
    output lc3b_btb_ctr                 o_upd_ctr,
    input  logic                        i_wr_en,
    input  logic [$clog2(ENTRIES)-1:0]  i_wr_idx,
    input  logic [TAG_BITS-1:0]         i_wr_tag,
    input  lc3b_word                    i_wr_target,
    input  lc3b_btb_ctr                 i_wr_ctr
);

    logic [ENTRIES-1:0]  r_valid;
    lc3b_btb_ctr         r_ctr    [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    lc3b_word            r_target [ENTRIES];

    // Valid and counter carry reset state; writes are dropped while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= BTB_WNT;
            end
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_ctr[i_wr_idx]   <= i_wr_ctr;
        end
    end

    // Tag and target are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst_n && i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    // Reads observe pre-write contents; no bypass from the write port.
    assign o_fetch_valid  = r_valid[i_fetch_idx];
    assign o_fetch_tag    = r_tag[i_fetch_idx];
    assign o_fetch_target = r_target[i_fetch_idx];
    assign o_fetch_ctr    = r_ctr[i_fetch_idx];

    assign o_upd_valid    = r_valid[i_upd_idx];
    assign o_upd_tag      = r_tag[i_upd_idx];
    assign o_upd_target   = r_target[i_upd_idx];
    assign o_upd_ctr      = r_ctr[i_upd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Fetch-stage next-PC predictor. Direct-mapped BTB with one
//               2-bit saturating direction counter per entry. Lookup is
//               combinational; training from write-back is applied on the
//               rising edge and becomes visible the following cycle.
// Ports       : clk, rst_n                - clock, sync active-low reset
//               fetch_pc                  - PC being fetched
//               predict_addr/taken/hit    - lookup results
//               upd_valid/pc/taken/target - resolved control-flow outcome
//               mispredict_cnt            - saturating count of wrong
//                                           stored predictions
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  lc3b_word    fetch_pc,
    output lc3b_word    predict_addr,
    output logic        predict_taken,
    output logic        predict_hit,
    input  logic        upd_valid,
    input  lc3b_word    upd_pc,
    input  logic        upd_taken,
    input  lc3b_word    upd_target,
    output logic [15:0] mispredict_cnt
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 15 - IDX_BITS;

    logic [IDX_BITS-1:0] w_fetch_idx;
    logic [TAG_BITS-1:0] w_fetch_tag;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0] w_upd_tag;

    logic                w_fetch_valid;
    logic [TAG_BITS-1:0] w_fetch_stored_tag;
    lc3b_word            w_fetch_target;
    lc3b_btb_ctr         w_fetch_ctr;

    logic                w_upd_valid_q;
    logic [TAG_BITS-1:0] w_upd_stored_tag;
    lc3b_word            w_upd_stored_target;
    lc3b_btb_ctr         w_upd_ctr;

    logic                w_upd_hit;
    logic                w_upd_pred_taken;
    logic                w_mispredict;
    logic                w_wr_en;
    lc3b_btb_ctr         w_wr_ctr;
    lc3b_word            w_wr_target;

    logic [15:0]         r_mispredict_cnt;

    // PC bit 0 is always zero for word-aligned fetches.
    logic                w_unused_pc_lsb;
    assign w_unused_pc_lsb = fetch_pc[0] ^ upd_pc[0];

    assign w_fetch_idx = fetch_pc[IDX_BITS:1];
    assign w_fetch_tag = fetch_pc[15:IDX_BITS+1];
    assign w_upd_idx   = upd_pc[IDX_BITS:1];
    assign w_upd_tag   = upd_pc[15:IDX_BITS+1];

    branch_target_predictor_btb_array #(
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS)
    ) u_btb_array (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_fetch_idx    (w_fetch_idx),
        .o_fetch_valid  (w_fetch_valid),
        .o_fetch_tag    (w_fetch_stored_tag),
        .o_fetch_target (w_fetch_target),
        .o_fetch_ctr    (w_fetch_ctr),
        .i_upd_idx      (w_upd_idx),
        .o_upd_valid    (w_upd_valid_q),
        .o_upd_tag      (w_upd_stored_tag),
        .o_upd_target   (w_upd_stored_target),
        .o_upd_ctr      (w_upd_ctr),
        .i_wr_en        (w_wr_en),
        .i_wr_idx       (w_upd_idx),
        .i_wr_tag       (w_upd_tag),
        .i_wr_target    (w_wr_target),
        .i_wr_ctr       (w_wr_ctr)
    );

    // ---------------- Lookup ----------------
    assign predict_hit   = w_fetch_valid && (w_fetch_stored_tag == w_fetch_tag);
    assign predict_taken = predict_hit && w_fetch_ctr[1];
    // Fall-through add wraps naturally in 16 bits.
    assign predict_addr  = predict_taken ? w_fetch_target : (fetch_pc + 16'd2);

    // ---------------- Training ----------------
    assign w_upd_hit        = w_upd_valid_q && (w_upd_stored_tag == w_upd_tag);
    assign w_upd_pred_taken = w_upd_hit && w_upd_ctr[1];

    // upd_valid gates everything so undriven upd_* fields cannot reach state.
    assign w_mispredict = upd_valid && (w_upd_pred_taken != upd_taken);
    assign w_wr_en      = upd_valid && (w_upd_hit || upd_taken);

    // A hit trains the existing counter; a taken miss allocates at weak-taken.
    // A not-taken hit rewrites the stored target unchanged.
    always_comb begin
        w_wr_ctr    = BTB_WT;
        w_wr_target = w_upd_stored_target;
        if (w_upd_hit) begin
            w_wr_ctr = upd_taken ? sat_inc(w_upd_ctr) : sat_dec(w_upd_ctr);
        end
        if (upd_taken) begin
            w_wr_target = upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mispredict_cnt <= 16'h0000;
        end else if (w_mispredict && (r_mispredict_cnt != 16'hFFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
    end

    assign mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_predictor
// Description : Directed self-checking bench for branch_target_predictor
//               with ENTRIES=8 (index = pc[3:1], tag = pc[15:4]).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    logic        clk;
    logic        rst_n;
    logic [15:0] fetch_pc;
    logic [15:0] predict_addr;
    logic        predict_taken;
    logic        predict_hit;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [15:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    branch_target_predictor #(
        .ENTRIES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .predict_addr   (predict_addr),
        .predict_taken  (predict_taken),
        .predict_hit    (predict_hit),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let inputs/outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic hit, input logic tk, input logic [15:0] addr,
                        input logic [15:0] cnt);
        fetch_pc = pc;
        #1;
        check({tag, "_hit"},   {15'd0, predict_hit},   {15'd0, hit});
        check({tag, "_taken"}, {15'd0, predict_taken}, {15'd0, tk});
        check({tag, "_addr"},  predict_addr, addr);
        check({tag, "_cnt"},   mispredict_cnt, cnt);
    endtask

    initial begin
        rst_n      = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = 16'h0000;
        upd_taken  = 1'b0;
        upd_target = 16'h0000;
        fetch_pc   = 16'h0040;
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Empty table after reset.
        look("reset", 16'h0040, 1'b0, 1'b0, 16'h0042, 16'd0);

        // Taken miss allocates at weak-taken; stored prediction was NT -> count 1.
        upd(16'h0040, 1'b1, 16'h0100);
        look("alloc", 16'h0040, 1'b1, 1'b1, 16'h0100, 16'd1);

        // 10 -> 01 (mispredicted), 01 -> 00 (correct).
        upd(16'h0040, 1'b0, 16'h0000);
        look("nt1", 16'h0040, 1'b1, 1'b0, 16'h0042, 16'd2);
        upd(16'h0040, 1'b0, 16'h0000);
        look("nt2", 16'h0040, 1'b1, 1'b0, 16'h0042, 16'd2);
        // Saturates at 00; a taken update then only reaches 01.
        upd(16'h0040, 1'b0, 16'h0000);
        look("nt3", 16'h0040, 1'b1, 1'b0, 16'h0042, 16'd2);
        upd(16'h0040, 1'b1, 16'h0100);
        look("t_from00", 16'h0040, 1'b1, 1'b0, 16'h0042, 16'd3);

        // 01 -> 10 (mispredicted), 10 -> 11, 11 stays 11 (both correct).
        upd(16'h0040, 1'b1, 16'h0100);
        look("t_to10", 16'h0040, 1'b1, 1'b1, 16'h0100, 16'd4);
        upd(16'h0040, 1'b1, 16'h0100);
        upd(16'h0040, 1'b1, 16'h0100);
        // 11 -> 10 still predicts taken, but this update mispredicted.
        upd(16'h0040, 1'b0, 16'h0000);
        look("sat_hi", 16'h0040, 1'b1, 1'b1, 16'h0100, 16'd5);

        // 0x0050 aliases index 0 with a different tag and evicts 0x0040.
        upd(16'h0050, 1'b1, 16'h0200);
        look("alias_old", 16'h0040, 1'b0, 1'b0, 16'h0042, 16'd6);
        look("alias_new", 16'h0050, 1'b1, 1'b1, 16'h0200, 16'd6);

        // Same-cycle lookup and update at 0x0060: lookup sees pre-update table.
        fetch_pc   = 16'h0060;
        upd_valid  = 1'b1;
        upd_pc     = 16'h0060;
        upd_taken  = 1'b1;
        upd_target = 16'h0300;
        #1;
        check("same_cyc_addr", predict_addr, 16'h0062);
        check("same_cyc_hit", {15'd0, predict_hit}, 16'd0);
        tick();
        upd_valid = 1'b0;
        #1;
        look("same_next", 16'h0060, 1'b1, 1'b1, 16'h0300, 16'd7);

        // Not-taken miss changes nothing and was predicted correctly.
        upd(16'h0070, 1'b0, 16'hDEAD);
        look("nt_miss", 16'h0070, 1'b0, 1'b0, 16'h0072, 16'd7);
        look("nt_miss_keep", 16'h0060, 1'b1, 1'b1, 16'h0300, 16'd7);

        // Separate index is independent of index 0.
        look("idx1_empty", 16'h0042, 1'b0, 1'b0, 16'h0044, 16'd7);
        upd(16'h0042, 1'b1, 16'h1234);
        look("idx1", 16'h0042, 1'b1, 1'b1, 16'h1234, 16'd8);
        look("idx0_keep", 16'h0060, 1'b1, 1'b1, 16'h0300, 16'd8);

        // Fall-through wraps at the top of the address space.
        look("wrap", 16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'd8);

        // Update presented during reset is dropped.
        rst_n      = 1'b0;
        upd_valid  = 1'b1;
        upd_pc     = 16'hFFFE;
        upd_taken  = 1'b1;
        upd_target = 16'h5555;
        tick();
        rst_n     = 1'b1;
        upd_valid = 1'b0;
        #1;
        look("rst_upd", 16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'd0);
        look("rst_clr", 16'h0060, 1'b0, 1'b0, 16'h0062, 16'd0);

        // Unknown update fields with upd_valid low leave state alone.
        upd_pc     = 16'hxxxx;
        upd_taken  = 1'bx;
        upd_target = 16'hxxxx;
        tick();
        tick();
        look("x_idle", 16'h0060, 1'b0, 1'b0, 16'h0062, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
